// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: shared FSM state type, fault cause codes and funct3 size constants
// for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] CAUSE_NONE        = 3'd0;
  localparam logic [2:0] CAUSE_MISALIGN_LD = 3'd1;
  localparam logic [2:0] CAUSE_MISALIGN_ST = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT     = 3'd3;
  localparam logic [2:0] CAUSE_ILLEGAL     = 3'd4;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // funct3[2] selects zero-extension on loads; stores never set it.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store,
                                    input int data_w);
    logic ok;
    if (is_store) begin
      ok = !f3[2] && ((f3[1:0] != SIZE_D) || (data_w == 64));
    end else begin
      case (f3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ok = 1'b1;
        3'd3, 3'd6:                   ok = (data_w == 64);
        default:                      ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// lsu_if: request/response handshake, pipeline controls and memory bus of the
// load/store unit. The unit connects through the slave modport.
interface lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                hlt;
  logic                flush;
  logic                req_valid;
  logic                req_ready;
  logic                req_store;
  logic [2:0]          funct3;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         offset;
  logic [DATA_W-1:0]   wdata;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_fault;
  logic [2:0]          rsp_cause;
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  hlt, flush, req_valid, req_store, funct3, base, offset, wdata,
           mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_fault, rsp_cause,
           mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output hlt, flush, req_valid, req_store, funct3, base, offset, wdata,
           mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_fault, rsp_cause,
           mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// lsu_lane: combinational byte-lane steering -- store replication and strobes,
// load extraction with zero/sign extension.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [1:0]        st_size,
  input  logic [OFF_W-1:0]  st_off,
  input  logic [DATA_W-1:0] st_wdata_in,
  output logic [DATA_W-1:0] st_wdata,
  output logic [NB-1:0]     st_wstrb,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [NB-1:0]     st_mask;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_keep;
  logic              ld_sign;

  always_comb begin
    st_wdata = st_wdata_in;
    st_mask  = '1;
    case (st_size)
      SIZE_B: begin
        st_wdata = {NB{st_wdata_in[7:0]}};
        st_mask  = NB'(1);
      end
      SIZE_H: begin
        st_wdata = {(NB/2){st_wdata_in[15:0]}};
        st_mask  = NB'(3);
      end
      SIZE_W: begin
        st_wdata = {(NB/4){st_wdata_in[31:0]}};
        st_mask  = NB'(15);
      end
      default: ;
    endcase
    st_wstrb = st_mask << st_off;
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    ld_keep  = '1;
    ld_sign  = 1'b0;
    case (ld_size)
      SIZE_B: begin ld_keep = DATA_W'(8'hFF);         ld_sign = ld_shift[7];  end
      SIZE_H: begin ld_keep = DATA_W'(16'hFFFF);      ld_sign = ld_shift[15]; end
      SIZE_W: begin ld_keep = DATA_W'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: ;
    endcase
    ld_data = (ld_shift & ld_keep) | ({DATA_W{ld_sign & ~ld_uns}} & ~ld_keep);
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: single-outstanding RISC-V load/store engine (IDLE/BUS/RESP).
// Define LSU_TIMEOUT_EN to fault a bus access that waits TIMEOUT cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic              st_q, st_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              flushed_q, flushed_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [2:0]        rsp_cause_q, rsp_cause_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [ADDR_W-1:0] ea;
  logic              accept;
  logic              legal;
  logic [2:0]        align_mask;
  logic              misaligned;
  logic [DATA_W-1:0] lane_wdata;
  logic [NB-1:0]     lane_wstrb;
  logic [DATA_W-1:0] lane_ld;

`ifdef LSU_TIMEOUT_EN
  localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign ea         = bus.base + ADDR_W'($signed(bus.offset));
  assign accept     = bus.req_valid && (state_q == IDLE) && !bus.hlt && !bus.flush;
  assign legal      = f3_legal(bus.funct3, bus.req_store, DATA_W);
  assign misaligned = |(ea[2:0] & align_mask);

  always_comb begin
    case (bus.funct3[1:0])
      SIZE_B:  align_mask = 3'b000;
      SIZE_H:  align_mask = 3'b001;
      SIZE_W:  align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .st_size     (bus.funct3[1:0]),
    .st_off      (ea[OFF_W-1:0]),
    .st_wdata_in (bus.wdata),
    .st_wdata    (lane_wdata),
    .st_wstrb    (lane_wstrb),
    .ld_size     (size_q),
    .ld_uns      (uns_q),
    .ld_off      (off_q),
    .ld_rdata    (bus.mem_rdata),
    .ld_data     (lane_ld)
  );

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    flushed_d   = flushed_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_cause_d = rsp_cause_q;
    rsp_data_d  = rsp_data_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          st_d      = bus.req_store;
          size_d    = bus.funct3[1:0];
          uns_d     = bus.funct3[2];
          off_d     = ea[OFF_W-1:0];
          flushed_d = 1'b0;
          if (!legal || misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_data_d  = '0;
            rsp_cause_d = !legal       ? CAUSE_ILLEGAL :
                          bus.req_store ? CAUSE_MISALIGN_ST : CAUSE_MISALIGN_LD;
          end else begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
            mem_addr_d  = {ea[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_d = lane_wdata;
            mem_wstrb_d = bus.req_store ? lane_wstrb : '0;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      BUS: begin
        // A flush only marks the access; the bus cycle always runs to completion.
        if (bus.flush) flushed_d = 1'b1;
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = '0;
          if (flushed_q || bus.flush) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_cause_d = CAUSE_NONE;
            rsp_data_d  = st_q ? '0 : lane_ld;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = '0;
          if (flushed_q || bus.flush) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_cause_d = CAUSE_TIMEOUT;
            rsp_data_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.flush || !bus.hlt) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_cause_d = CAUSE_NONE;
          rsp_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      st_q        <= 1'b0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      off_q       <= '0;
      flushed_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_cause_q <= CAUSE_NONE;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      flushed_q   <= flushed_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_cause_q <= rsp_cause_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_cause = rsp_cause_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire
